// File: rtl/regfile_wb_arb.sv
// regfile_wb_arb: writeback arbiter and write stage for the 2R1W integer register file.
//
// Two writeback sources share the register file's single write port:
//   port 0 = ALU, port 1 = load/store unit.
// At most one source is granted per cycle, round-robin on contention. The winning write is
// registered onto wr_en/rd/dataRd and forwarded to both read ports in the same cycle.
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   req{0,1}_valid/_rd/_data      writeback requests (valid/ready handshake)
//   req{0,1}_ready                request accepted this cycle (0 while rst is high)
//   wr_en, rd, dataRd             registered write to the register file
//   rs1, rs2                      read indices shared with the register file
//   fwd1_hit, fwd2_hit, fwd_data  in-flight write bypass for the read ports
//   conflict_cnt                  saturating count of cycles with both ports valid

module regfile_wb_arb #(
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,

  input  logic              req0_valid,
  input  logic [ADDR_W-1:0] req0_rd,
  input  logic [DATA_W-1:0] req0_data,
  output logic              req0_ready,

  input  logic              req1_valid,
  input  logic [ADDR_W-1:0] req1_rd,
  input  logic [DATA_W-1:0] req1_data,
  output logic              req1_ready,

  output logic              wr_en,
  output logic [ADDR_W-1:0] rd,
  output logic [DATA_W-1:0] dataRd,

  input  logic [ADDR_W-1:0] rs1,
  input  logic [ADDR_W-1:0] rs2,
  output logic              fwd1_hit,
  output logic              fwd2_hit,
  output logic [DATA_W-1:0] fwd_data,

  output logic [CNT_W-1:0]  conflict_cnt
);

  // Round-robin pointer: names the port that wins the next conflict.
  logic              rr_ptr_q, rr_ptr_d;
  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] rd_q, rd_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic              gnt0, gnt1, gnt_any, conflict;
  logic [ADDR_W-1:0] sel_rd;
  logic [DATA_W-1:0] sel_data;

  // Grant
  always_comb begin
    conflict = req0_valid && req1_valid;
    gnt0     = req0_valid && (!req1_valid || !rr_ptr_q);
    gnt1     = req1_valid && (!req0_valid ||  rr_ptr_q);
    gnt_any  = gnt0 || gnt1;
    sel_rd   = gnt1 ? req1_rd   : req0_rd;
    sel_data = gnt1 ? req1_data : req0_data;
  end

  // Ready is masked during reset so nothing is consumed on the reset edge.
  assign req0_ready = gnt0 && !rst;
  assign req1_ready = gnt1 && !rst;

  // Next state
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    wr_en_d  = 1'b0;
    rd_d     = '0;
    data_d   = '0;
    cnt_d    = cnt_q;

    // Any grant, contended or not, hands priority to the other port.
    if (gnt0) begin
      rr_ptr_d = 1'b1;
    end else if (gnt1) begin
      rr_ptr_d = 1'b0;
    end

    // x0 writes are consumed but leave the stage idle.
    if (gnt_any && (sel_rd != '0)) begin
      wr_en_d = 1'b1;
      rd_d    = sel_rd;
      data_d  = sel_data;
    end

    if (conflict && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // State
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_q <= 1'b0;
      wr_en_q  <= 1'b0;
      rd_q     <= '0;
      data_q   <= '0;
      cnt_q    <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      wr_en_q  <= wr_en_d;
      rd_q     <= rd_d;
      data_q   <= data_d;
      cnt_q    <= cnt_d;
    end
  end

  // Outputs
  assign wr_en        = wr_en_q;
  assign rd           = rd_q;
  assign dataRd       = data_q;
  assign conflict_cnt = cnt_q;

  // Forwarding: x0 is never forwarded since it always reads as zero.
  assign fwd1_hit = wr_en_q && (rd_q == rs1) && (rs1 != '0);
  assign fwd2_hit = wr_en_q && (rd_q == rs2) && (rs2 != '0);
  assign fwd_data = data_q;

endmodule

// File: tb/tb_regfile_wb_arb.sv
module tb_regfile_wb_arb;

  localparam int unsigned ADDR_W = 5;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned CNT_W  = 4;
  localparam int          CNT_MAX = (1 << CNT_W) - 1;

  logic              clk = 1'b0;
  logic              rst;
  logic              req0_valid, req1_valid;
  logic [ADDR_W-1:0] req0_rd, req1_rd;
  logic [DATA_W-1:0] req0_data, req1_data;
  logic              req0_ready, req1_ready;
  logic              wr_en;
  logic [ADDR_W-1:0] rd;
  logic [DATA_W-1:0] dataRd;
  logic [ADDR_W-1:0] rs1, rs2;
  logic              fwd1_hit, fwd2_hit;
  logic [DATA_W-1:0] fwd_data;
  logic [CNT_W-1:0]  conflict_cnt;

  int checks = 0;
  int errors = 0;

  regfile_wb_arb #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W),
    .CNT_W (CNT_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req0_valid  (req0_valid),
    .req0_rd     (req0_rd),
    .req0_data   (req0_data),
    .req0_ready  (req0_ready),
    .req1_valid  (req1_valid),
    .req1_rd     (req1_rd),
    .req1_data   (req1_data),
    .req1_ready  (req1_ready),
    .wr_en       (wr_en),
    .rd          (rd),
    .dataRd      (dataRd),
    .rs1         (rs1),
    .rs2         (rs2),
    .fwd1_hit    (fwd1_hit),
    .fwd2_hit    (fwd2_hit),
    .fwd_data    (fwd_data),
    .conflict_cnt(conflict_cnt)
  );

  always #5 clk = ~clk;

  // Advance one clock; inputs may be changed right after return.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    req0_valid = 1'b0; req0_rd = '0; req0_data = '0;
    req1_valid = 1'b0; req1_rd = '0; req1_data = '0;
    rs1 = '0; rs2 = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    req0_valid = 1'b1; req0_rd = 5'd3; req0_data = 32'h1111_1111;
    req1_valid = 1'b1; req1_rd = 5'd4; req1_data = 32'h2222_2222;
    for (int c = 0; c < 3; c++) begin
      tick();
      #1;
      checks++;
      if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
        errors++;
        $display("FAIL reset_ready cycle %0d: got %b%b want 00", c, req0_ready, req1_ready);
      end
      checks++;
      if (wr_en !== 1'b0 || rd !== '0 || conflict_cnt !== '0) begin
        errors++;
        $display("FAIL reset_state cycle %0d: got wr_en=%b rd=%0d cnt=%0d want 0 0 0",
                 c, wr_en, rd, conflict_cnt);
      end
    end
    rst = 1'b0;
    idle_inputs();
    tick();
  endtask

  task automatic test_single();
    do_reset();
    req0_valid = 1'b1; req0_rd = 5'd5; req0_data = 32'hDEAD_BEEF;
    #1;
    checks++;
    if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
      errors++;
      $display("FAIL single_ready: got %b%b want 10", req0_ready, req1_ready);
    end
    tick();
    req0_valid = 1'b0;
    #1;
    checks++;
    if (wr_en !== 1'b1 || rd !== 5'd5 || dataRd !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL single_write: got wr_en=%b rd=%0d data=%h want 1 5 deadbeef",
               wr_en, rd, dataRd);
    end
    tick();
    checks++;
    if (wr_en !== 1'b0 || rd !== '0 || dataRd !== '0) begin
      errors++;
      $display("FAIL single_idle: got wr_en=%b rd=%0d data=%h want 0 0 0", wr_en, rd, dataRd);
    end
  endtask

  task automatic test_contention();
    int exp_g[4]  = '{0, 1, 0, 1};
    int exp_rd[4] = '{1, 11, 2, 12};
    int i0 = 0;
    int i1 = 0;
    do_reset();
    for (int c = 0; c < 4; c++) begin
      req0_valid = 1'b1; req0_rd = 5'(1 + i0);  req0_data = 32'hA000_0000 + 32'(1 + i0);
      req1_valid = 1'b1; req1_rd = 5'(11 + i1); req1_data = 32'hB000_0000 + 32'(11 + i1);
      #1;
      checks++;
      if (req0_ready !== (exp_g[c] == 0) || req1_ready !== (exp_g[c] == 1)) begin
        errors++;
        $display("FAIL contention_grant cycle %0d: got %b%b want port %0d",
                 c, req0_ready, req1_ready, exp_g[c]);
      end
      if (c > 0) begin
        checks++;
        if (wr_en !== 1'b1 || rd !== 5'(exp_rd[c-1])) begin
          errors++;
          $display("FAIL contention_write cycle %0d: got wr_en=%b rd=%0d want 1 %0d",
                   c, wr_en, rd, exp_rd[c-1]);
        end
      end
      tick();
      if (exp_g[c] == 0) i0++; else i1++;
    end
    idle_inputs();
    #1;
    checks++;
    if (wr_en !== 1'b1 || rd !== 5'd12 || dataRd !== 32'hB000_000C) begin
      errors++;
      $display("FAIL contention_last: got wr_en=%b rd=%0d data=%h want 1 12 b000000c",
               wr_en, rd, dataRd);
    end
    checks++;
    if (conflict_cnt !== 4'd4) begin
      errors++;
      $display("FAIL contention_cnt: got %0d want 4", conflict_cnt);
    end
    tick();
  endtask

  task automatic test_x0();
    do_reset();
    req1_valid = 1'b1; req1_rd = '0; req1_data = 32'h1234_5678;
    rs1 = '0;
    #1;
    checks++;
    if (req1_ready !== 1'b1 || req0_ready !== 1'b0) begin
      errors++;
      $display("FAIL x0_ready: got %b%b want 01", req0_ready, req1_ready);
    end
    tick();
    req1_valid = 1'b0;
    #1;
    checks++;
    if (wr_en !== 1'b0 || rd !== '0 || dataRd !== '0 || fwd1_hit !== 1'b0) begin
      errors++;
      $display("FAIL x0_drop: got wr_en=%b rd=%0d data=%h hit=%b want 0 0 0 0",
               wr_en, rd, dataRd, fwd1_hit);
    end
    tick();
  endtask

  task automatic test_forward();
    do_reset();
    req0_valid = 1'b1; req0_rd = 5'd7; req0_data = 32'hA5A5_A5A5;
    tick();
    req0_valid = 1'b0;
    rs1 = 5'd7; rs2 = 5'd8;
    #1;
    checks++;
    if (fwd1_hit !== 1'b1 || fwd2_hit !== 1'b0 || fwd_data !== 32'hA5A5_A5A5) begin
      errors++;
      $display("FAIL forward: got hit1=%b hit2=%b data=%h want 1 0 a5a5a5a5",
               fwd1_hit, fwd2_hit, fwd_data);
    end
    tick();
    #1;
    checks++;
    if (fwd1_hit !== 1'b0) begin
      errors++;
      $display("FAIL forward_clear: got hit1=%b want 0", fwd1_hit);
    end
    idle_inputs();
  endtask

  task automatic test_saturation_mid_reset();
    do_reset();
    req0_valid = 1'b1; req0_rd = 5'd9;  req0_data = 32'h0000_0009;
    req1_valid = 1'b1; req1_rd = 5'd10; req1_data = 32'h0000_000A;
    // 21 cycles: the last grant goes to port 0, so only reset can give port 0 priority.
    for (int c = 1; c <= 21; c++) begin
      tick();
      if (c == 14 || c == 20 || c == 21) begin
        checks++;
        if (conflict_cnt !== 4'(c > CNT_MAX ? CNT_MAX : c)) begin
          errors++;
          $display("FAIL sat_cnt after %0d: got %0d want %0d",
                   c, conflict_cnt, (c > CNT_MAX ? CNT_MAX : c));
        end
      end
    end
    checks++;
    if (wr_en !== 1'b1 || rd !== 5'd9) begin
      errors++;
      $display("FAIL sat_staged: got wr_en=%b rd=%0d want 1 9", wr_en, rd);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
      errors++;
      $display("FAIL midrst_ready: got %b%b want 00", req0_ready, req1_ready);
    end
    tick();
    rst = 1'b0;
    #1;
    checks++;
    if (wr_en !== 1'b0 || conflict_cnt !== '0) begin
      errors++;
      $display("FAIL midrst_state: got wr_en=%b cnt=%0d want 0 0", wr_en, conflict_cnt);
    end
    checks++;
    if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
      errors++;
      $display("FAIL midrst_priority: got %b%b want 10", req0_ready, req1_ready);
    end
    tick();
    idle_inputs();
    tick();
  endtask

  // Random traffic against a transaction-level model: each port holds a pending write until
  // it is taken; the model tracks which port is preferred, the write in flight, and the count.
  task automatic test_random();
    bit              pend[2];
    bit [ADDR_W-1:0] p_rd[2];
    bit [DATA_W-1:0] p_data[2];
    int              pref;
    bit              m_wen;
    bit [ADDR_W-1:0] m_rd;
    bit [DATA_W-1:0] m_data;
    int              m_cnt;
    int              g;
    bit              exp_h1, exp_h2;

    do_reset();
    pend = '{0, 0};
    pref = 0; m_wen = 0; m_rd = '0; m_data = '0; m_cnt = 0;

    for (int c = 0; c < 600; c++) begin
      for (int p = 0; p < 2; p++) begin
        if (!pend[p] && ($urandom_range(0, 99) < 60)) begin
          pend[p]   = 1'b1;
          p_rd[p]   = ($urandom_range(0, 7) == 0) ? '0 : ADDR_W'($urandom);
          p_data[p] = $urandom;
        end
      end
      rst = ($urandom_range(0, 49) == 0);
      req0_valid = pend[0]; req0_rd = p_rd[0]; req0_data = p_data[0];
      req1_valid = pend[1]; req1_rd = p_rd[1]; req1_data = p_data[1];
      case ($urandom_range(0, 3))
        0:       rs1 = '0;
        1:       rs1 = m_rd;
        default: rs1 = ADDR_W'($urandom);
      endcase
      rs2 = ($urandom_range(0, 1) == 0) ? m_rd : ADDR_W'($urandom);
      #1;

      if (rst)                  g = -1;
      else if (pend[0] && pend[1]) g = pref;
      else if (pend[0])         g = 0;
      else if (pend[1])         g = 1;
      else                      g = -1;

      exp_h1 = m_wen && (m_rd == rs1) && (rs1 != '0);
      exp_h2 = m_wen && (m_rd == rs2) && (rs2 != '0);

      checks++;
      if (req0_ready !== (g == 0) || req1_ready !== (g == 1)) begin
        errors++;
        $display("FAIL rand_grant cycle %0d: got %b%b want grant %0d", c,
                 req0_ready, req1_ready, g);
      end
      checks++;
      if (wr_en !== m_wen || rd !== m_rd || dataRd !== m_data) begin
        errors++;
        $display("FAIL rand_write cycle %0d: got %b %0d %h want %b %0d %h", c,
                 wr_en, rd, dataRd, m_wen, m_rd, m_data);
      end
      checks++;
      if (fwd1_hit !== exp_h1 || fwd2_hit !== exp_h2 || fwd_data !== m_data) begin
        errors++;
        $display("FAIL rand_fwd cycle %0d: got %b %b %h want %b %b %h", c,
                 fwd1_hit, fwd2_hit, fwd_data, exp_h1, exp_h2, m_data);
      end
      checks++;
      if (conflict_cnt !== CNT_W'(m_cnt)) begin
        errors++;
        $display("FAIL rand_cnt cycle %0d: got %0d want %0d", c, conflict_cnt, m_cnt);
      end

      // Model update for the coming clock edge.
      if (rst) begin
        pref = 0; m_wen = 0; m_rd = '0; m_data = '0; m_cnt = 0;
      end else begin
        if (pend[0] && pend[1] && m_cnt < CNT_MAX) m_cnt = m_cnt + 1;
        if (g >= 0) begin
          pref = 1 - g;
          pend[g] = 1'b0;
          if (p_rd[g] != '0) begin
            m_wen = 1; m_rd = p_rd[g]; m_data = p_data[g];
          end else begin
            m_wen = 0; m_rd = '0; m_data = '0;
          end
        end else begin
          m_wen = 0; m_rd = '0; m_data = '0;
        end
      end
      tick();
    end
    rst = 1'b0;
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    rst = 1'b1;
    test_reset();
    test_single();
    test_contention();
    test_x0();
    test_forward();
    test_saturation_mid_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/regfile_wb_arb.md
# regfile_wb_arb

Writeback arbiter and write stage for the 2R1W integer register file. Two writeback sources (port 0 = ALU, port 1 = load/store unit) compete for the register file's single write port. The block grants at most one source per cycle, round-robin, and registers the winning write onto `rd`/`dataRd`. It also forwards the in-flight write to both read ports, so decode sees the value in the same cycle.

## Interface

Parameters:
- `ADDR_W`, default `REGFILE_SIZE` (5): register index width.
- `DATA_W`, default `INT32W` (32): register data width.
- `CNT_W`, default 16: width of the conflict statistics counter.

Ports:
- `clk`  in  1  clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req0_valid`  in  1  port 0 has a write pending.
- `req0_rd`  in  ADDR_W  port 0 destination register.
- `req0_data`  in  DATA_W  port 0 write data.
- `req0_ready`  out  1  port 0 write accepted this cycle.
- `req1_valid`, `req1_rd`, `req1_data`, `req1_ready`: same as port 0, for port 1.
- `wr_en`  out  1  registered write strobe to the register file.
- `rd`  out  ADDR_W  registered write index, to register file `rd`.
- `dataRd`  out  DATA_W  registered write data, to register file `dataRd`.
- `rs1`, `rs2`  in  ADDR_W  read indices, shared with the register file.
- `fwd1_hit`, `fwd2_hit`  out  1  in-flight write matches `rs1` / `rs2`.
- `fwd_data`  out  DATA_W  forwarded value (equals `dataRd`).
- `conflict_cnt`  out  CNT_W  saturating count of contention cycles.

## Operation

- **Grant (combinational):**
  - Only one port valid: that port is granted.
  - Both valid: the port selected by `rr_ptr` is granted.
  - Neither valid: no grant.
  - `reqN_ready` = grant to N, forced 0 while `rst` is high.
- **Round-robin state:**
  - 1-bit `rr_ptr`, reset value 0 (port 0 wins the first conflict).
  - After any grant to port k, `rr_ptr <= ~k`.
  - A waiting port is therefore granted within 1 cycle of contention.
- **Handshake:**
  - A transfer occurs when `valid && ready`.
  - A requester holds `valid`, `rd` and `data` stable until accepted.
  - `ready` may depend combinationally on `valid`.
  - Requesters must not make `valid` depend on `ready`.
- **Write stage (registered):**
  - On accept with a nonzero destination: `wr_en <= 1`, `rd <= req_rd`, `dataRd <= req_data`.
  - On accept with destination x0: the request is consumed (`ready` = 1), and the stage behaves as idle.
  - With no accept, the stage is idle: `wr_en <= 0`, `rd <= 0`, `dataRd <= 0`. A register file without an enable therefore sees only harmless x0 writes.
- **Forwarding (combinational):**
  - `fwdN_hit` = `wr_en && rd == rsN && rsN != 0`.
  - `fwd_data = dataRd`.
  - Consumers mux `fwd_data` over the register file read data when hit.
- **Statistics:**
  - `conflict_cnt` increments in each cycle where `req0_valid && req1_valid`.
  - It saturates at all-ones and does not wrap.
- **Same destination back-to-back:** the later write simply follows one cycle behind. No merge, no reorder.

## Timing

- Reset values: `wr_en` = 0, `rd` = 0, `dataRd` = 0, `rr_ptr` = 0, `conflict_cnt` = 0. Ready and hit outputs are 0 during reset.
- Latency: a request accepted in cycle N appears on `wr_en`/`rd`/`dataRd` in cycle N+1. The register file commits it at the end of cycle N+1.
- Throughput: one write per cycle sustained, from either port or alternating.
- Forwarding: `fwdN_hit` is valid in cycle N+1, the same cycle the write is on the port.
- Reset mid-operation:
  - A request presented during the reset cycle is not accepted and must be re-held afterwards.
  - A write in the stage register at the reset edge is discarded (`wr_en` = 0 the next cycle).
- Simultaneous events: `rr_ptr` updates only on a grant. Single-port traffic flips `rr_ptr` too, so the idle port wins the next conflict.

## Test plan

- **Reset:** hold `rst`=1 for 3 cycles with both valid.
  - Expect: both `ready` = 0, `wr_en` = 0, `rd` = 0, `conflict_cnt` = 0.
- **Single writes:** port 0 writes r5 = 0xDEADBEEF in cycle N.
  - Expect: `req0_ready` = 1 in N; `wr_en` = 1, `rd` = 5, `dataRd` = 0xDEADBEEF in N+1; `wr_en` = 0 in N+2.
- **Contention:** both ports valid continuously for 4 cycles (port 0 → r1..r4, port 1 → r11..r14), starting from reset.
  - Expect grants 0, 1, 0, 1 and writes r1, r11, r2, r12, each 1 cycle later.
  - Expect `conflict_cnt` = 4 at the end.
- **x0 drop:** port 1 writes x0 = 0x12345678.
  - Expect: `req1_ready` = 1; the next cycle has `wr_en` = 0, `rd` = 0.
  - With `rs1` = 0, expect `fwd1_hit` = 0.
- **Forwarding:** write r7 = 0xA5A5A5A5, then in cycle N+1 drive `rs1` = 7, `rs2` = 8.
  - Expect `fwd1_hit` = 1, `fwd2_hit` = 0, `fwd_data` = 0xA5A5A5A5.
- **Saturation and mid-reset:**
  - With `CNT_W` = 4, keep both valid for 20 cycles: `conflict_cnt` = 15.
  - Assert `rst` for 1 cycle while a write is staged: the next cycle has `wr_en` = 0, `conflict_cnt` = 0, and port 0 wins the next conflict.
